fp_fir_feeder: RTL and testbench
================================

FP_FIR_FEEDER -- requirements
Module: fp_fir_feeder

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 4: cycles between sample strobes; legal range 2..255.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: sample FIFO depth; power of two, 2..16.
REQ-003 SHALL have one clock and a synchronous, active-low reset; the clock is named Clk and the reset is named Rst.
REQ-004 Clk  input  1  clock, all state on rising edge.
REQ-005 Rst  input  1  synchronous active-low reset.
REQ-006 s_valid  input  1  upstream sample valid.
REQ-007 s_data  input  32  IEEE-754 single sample.
REQ-008 s_ready  output  1  FIFO not full; registered, no combinational path from any input.
REQ-009 coef_wr  input  1  shadow coefficient write strobe.
REQ-010 coef_addr  input  2  shadow index 0..3.
REQ-011 coef_data  input  32  IEEE-754 single coefficient.
REQ-012 coef_commit  input  1  request shadow-to-active transfer.
REQ-013 flush  input  1  empty FIFO, return to IDLE.
REQ-014 Xn  output  32  sample presented to the FP FIR.
REQ-015 x_stb  output  1  one-cycle pulse: Xn is a new sample and FIR delay line advances.
REQ-016 b0, b1, b2, b3  output  32 each  active coefficients.
REQ-017 underflow  output  1  sticky: a zero-stuffed sample was issued.
REQ-018 commit_pending  output  1  commit requested, not yet applied.

Function
REQ-019 Push SHALL occur when s_valid && s_ready; on simultaneous push and pop the occupancy SHALL be unchanged; when full, s_ready SHALL be 0 even if a pop occurs that cycle.
REQ-020 FSM states SHALL be IDLE, COUNT and ISSUE; IDLE -> COUNT when the FIFO becomes non-empty; COUNT -> ISSUE when the divider reaches SAMPLE_DIV-1; ISSUE -> COUNT always; any state -> IDLE on flush.
REQ-021 In ISSUE, x_stb SHALL be 1 for exactly one cycle and the FIFO head SHALL be popped into Xn; Xn SHALL hold between strobes.
REQ-022 Strobe spacing in steady state SHALL be exactly SAMPLE_DIV cycles; the first x_stb SHALL occur SAMPLE_DIV cycles after the first accepted push from IDLE.
REQ-023 In ISSUE with the FIFO empty, Xn SHALL be 32'h0000_0000, x_stb SHALL be 1 and underflow SHALL be set; underflow SHALL clear only on reset or flush.
REQ-024 coef_wr SHALL update shadow[coef_addr] on the next edge; shadow writes SHALL never alter b0..b3 directly.
REQ-025 coef_commit SHALL set commit_pending; when coef_wr and coef_commit coincide, that write SHALL be included in the commit.
REQ-026 A pending commit SHALL load b0..b3 from the shadow registers on the ISSUE cycle (same edge as the new Xn), or on the next edge if in IDLE, then clear commit_pending.
REQ-027 flush SHALL empty the FIFO, clear the divider and underflow, and leave Xn, b0..b3, the shadow registers and commit_pending unchanged; flush SHALL win over a simultaneous push.

Reset
REQ-028 While Rst=0: Xn, b0..b3 and the shadow registers SHALL be 0; x_stb, underflow and commit_pending SHALL be 0; s_ready SHALL be 0; the FIFO SHALL be empty; the state SHALL be IDLE.
REQ-029 s_ready SHALL be 1 on the first cycle after Rst returns high; reset mid-stream SHALL discard all queued samples with no x_stb emitted.

Configuration
REQ-030 With FP_FEEDER_NAN_SQUASH_EN defined, a pushed sample with exponent 8'hFF (Inf/NaN) SHALL be stored as 32'h0000_0000 and SHALL pulse output nan_seen for one cycle; without the macro, samples SHALL pass unmodified and the nan_seen port SHALL be absent.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, the FP zero constant, and the exponent-all-ones constant.
REQ-032 The FIFO SHALL be a separate sub-module, fp_sample_fifo, with parameter FIFO_DEPTH.

Verification
REQ-033 Push 3F80_0000, 4000_0000 and 4040_0000 back-to-back with SAMPLE_DIV=4 -> x_stb at cycles 4, 8 and 12 after the first push, Xn in order, then zero-stuffing with underflow=1 at cycle 16.
REQ-034 Hold s_valid=1 with no pops possible -> s_ready=0 after FIFO_DEPTH accepts; extra data is not lost or duplicated.
REQ-035 Write shadow 0..3 = 3E80_0000 and commit mid-COUNT -> b0..b3 change exactly on the next x_stb cycle; commit_pending=1 until then.
REQ-036 coef_wr(addr 2, 4120_0000) coincident with coef_commit in IDLE -> b2=4120_0000 on the next edge.
REQ-037 flush with 2 samples queued and underflow=1 -> FIFO empty, underflow=0, state IDLE, no x_stb; Rst low mid-COUNT -> all outputs zero.
REQ-038 With FP_FEEDER_NAN_SQUASH_EN defined, push 7FC0_0000 -> nan_seen pulse, later Xn=0000_0000 with x_stb=1.

Source files
------------

// File: rtl/fp_fir_feeder_pkg.sv
// Shared types and constants for the FP FIR sample feeder.
// FSM state encoding and IEEE-754 single-precision helpers.
package fp_fir_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    ISSUE = 2'd2
  } state_t;

  localparam logic [31:0] FP_ZERO  = 32'h0000_0000;
  localparam logic [7:0]  EXP_ONES = 8'hFF;

  function automatic logic is_inf_nan(input logic [31:0] x);
    return x[30:23] == EXP_ONES;
  endfunction

endpackage

// File: rtl/fp_sample_fifo.sv
// Sample FIFO for the FP FIR feeder, power-of-two depth.
// ready is registered from the next occupancy, low while in reset.
module fp_sample_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        flush,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        empty,
  output logic        ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);

  // Next occupancy: push and pop together leave it unchanged.
  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (pop && !push) begin
      count_next = count - 1'b1;
    end
  end

  // Pointers, occupancy and registered ready flag.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      ready <= (count_next != FULL_CNT);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fp_fir_feeder.sv
// Feeds IEEE-754 samples to an FP FIR at a fixed strobe rate.
// Define FP_FEEDER_NAN_SQUASH_EN to zero Inf/NaN samples on push.
module fp_fir_feeder
  import fp_fir_feeder_pkg::*;
#(
  parameter int SAMPLE_DIV = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  input  logic        coef_wr,
  input  logic [1:0]  coef_addr,
  input  logic [31:0] coef_data,
  input  logic        coef_commit,
  input  logic        flush,
  output logic [31:0] Xn,
  output logic        x_stb,
  output logic [31:0] b0,
  output logic [31:0] b1,
  output logic [31:0] b2,
  output logic [31:0] b3,
  output logic        underflow,
  output logic        commit_pending
`ifdef FP_FEEDER_NAN_SQUASH_EN
  ,
  output logic        nan_seen
`endif
);

  state_t           state;
  state_t           state_next;
  logic [7:0]       div;
  logic             push;
  logic             pop;
  logic             empty;
  logic             issue_go;
  logic             apply;
  logic [31:0]      wdata;
  logic [31:0]      head;
  logic [3:0][31:0] shadow;
  logic [3:0][31:0] shadow_nx;

  assign push     = s_valid && s_ready && !flush;
  assign issue_go = (state == COUNT) &&
                    (div == 8'(SAMPLE_DIV - 1)) && !flush;
  assign pop      = issue_go && !empty;
  assign apply    = (commit_pending || coef_commit) &&
                    (issue_go || state == IDLE);

`ifdef FP_FEEDER_NAN_SQUASH_EN
  assign wdata = is_inf_nan(s_data) ? FP_ZERO : s_data;

  // One-cycle flag for each squashed Inf/NaN sample.
  always_ff @(posedge Clk) begin
    if (!Rst) nan_seen <= 1'b0;
    else      nan_seen <= push && is_inf_nan(s_data);
  end
`else
  assign wdata = s_data;
`endif

  fp_sample_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .Clk  (Clk),
    .Rst  (Rst),
    .flush(flush),
    .push (push),
    .pop  (pop),
    .wdata(wdata),
    .rdata(head),
    .empty(empty),
    .ready(s_ready)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (!Rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next state: a push from IDLE starts the divider.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (push || !empty) state_next = COUNT;
        COUNT:   if (issue_go) state_next = ISSUE;
        ISSUE:   state_next = COUNT;
        default: state_next = IDLE;
      endcase
    end
  end

  // Strobe is high for the single ISSUE cycle.
  always_comb begin
    x_stb = (state == ISSUE);
  end

  // Divider: ISSUE and the entry into COUNT are cycle 0 of a period.
  always_ff @(posedge Clk) begin
    if (!Rst || flush) begin
      div <= '0;
    end else if (state_next == COUNT && state != COUNT) begin
      div <= 8'd1;
    end else if (state == COUNT) begin
      div <= div + 8'd1;
    end
  end

  // Sample output and sticky underflow, updated entering ISSUE.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      Xn        <= FP_ZERO;
      underflow <= 1'b0;
    end else if (flush) begin
      underflow <= 1'b0;
    end else if (issue_go) begin
      Xn <= empty ? FP_ZERO : head;
      if (empty) underflow <= 1'b1;
    end
  end

  // Shadow bank with this cycle's write merged in.
  always_comb begin
    shadow_nx = shadow;
    if (coef_wr) shadow_nx[coef_addr] = coef_data;
  end

  // Shadow registers, active coefficients and commit tracking.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      shadow         <= '0;
      {b3, b2, b1, b0} <= '0;
      commit_pending <= 1'b0;
    end else begin
      shadow <= shadow_nx;
      if (apply) begin
        {b3, b2, b1, b0} <= shadow_nx;
        commit_pending   <= 1'b0;
      end else if (coef_commit) begin
        commit_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fp_fir_feeder.sv
// Directed self-checking bench for fp_fir_feeder (SAMPLE_DIV=4, depth 4).
// Covers FP_FEEDER_NAN_SQUASH_EN behaviour when that macro is defined.
module tb_fp_fir_feeder;
  import fp_fir_feeder_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        coef_wr;
  logic [1:0]  coef_addr;
  logic [31:0] coef_data;
  logic        coef_commit;
  logic        flush;
  logic [31:0] Xn;
  logic        x_stb;
  logic [31:0] b0, b1, b2, b3;
  logic        underflow;
  logic        commit_pending;
`ifdef FP_FEEDER_NAN_SQUASH_EN
  logic        nan_seen;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  fp_fir_feeder #(
    .SAMPLE_DIV(4),
    .FIFO_DEPTH(4)
  ) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .coef_wr       (coef_wr),
    .coef_addr     (coef_addr),
    .coef_data     (coef_data),
    .coef_commit   (coef_commit),
    .flush         (flush),
    .Xn            (Xn),
    .x_stb         (x_stb),
    .b0            (b0),
    .b1            (b1),
    .b2            (b2),
    .b3            (b3),
    .underflow     (underflow),
    .commit_pending(commit_pending)
`ifdef FP_FEEDER_NAN_SQUASH_EN
    ,
    .nan_seen      (nan_seen)
`endif
  );

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      tick;
      chk1("no_stb", x_stb, 1'b0);
    end
  endtask

  task automatic wait_stb(input int max);
    int k;
    k = 0;
    do begin
      tick;
      k++;
    end while (x_stb !== 1'b1 && k < max);
    chk1("stb_timeout", x_stb, 1'b1);
  endtask

  initial begin
    int idx;
    logic acc;

    Rst = 1'b0; s_valid = 1'b0; s_data = '0;
    coef_wr = 1'b0; coef_addr = '0; coef_data = '0;
    coef_commit = 1'b0; flush = 1'b0;
    tick;
    tick;
    chk1("rst_ready", s_ready, 1'b0);
    chk("rst_xn", Xn, 32'h0);
    chk1("rst_stb", x_stb, 1'b0);
    chk1("rst_uf", underflow, 1'b0);
    chk1("rst_pend", commit_pending, 1'b0);
    chk("rst_b0", b0, 32'h0);
    Rst = 1'b1;
    tick;
    chk1("ready_after_rst", s_ready, 1'b1);

    // Three back-to-back samples, strobes at 4/8/12, stuffing at 16.
    s_valid = 1'b1; s_data = 32'h3F80_0000; tick;
    s_data = 32'h4000_0000; tick;
    s_data = 32'h4040_0000; tick;
    s_valid = 1'b0; s_data = '0;
    chk1("c3_stb", x_stb, 1'b0);
    tick;
    chk1("c4_stb", x_stb, 1'b1);
    chk("c4_xn", Xn, 32'h3F80_0000);
    gap(3);
    tick;
    chk1("c8_stb", x_stb, 1'b1);
    chk("c8_xn", Xn, 32'h4000_0000);
    gap(3);
    tick;
    chk1("c12_stb", x_stb, 1'b1);
    chk("c12_xn", Xn, 32'h4040_0000);
    chk1("c12_uf", underflow, 1'b0);
    gap(3);
    tick;
    chk1("c16_stb", x_stb, 1'b1);
    chk("c16_xn", Xn, 32'h0);
    chk1("c16_uf", underflow, 1'b1);

    // Queue two samples, then flush together with a third push.
    s_valid = 1'b1; s_data = 32'h40A0_0000; tick;
    s_data = 32'h40C0_0000; tick;
    chk1("pre_flush_uf", underflow, 1'b1);
    flush = 1'b1; s_data = 32'h40E0_0000; tick;
    flush = 1'b0; s_valid = 1'b0;
    chk1("flush_uf", underflow, 1'b0);
    chk1("flush_stb", x_stb, 1'b0);
    chk1("flush_empty", dut.u_fifo.empty, 1'b1);
    chk("flush_state", 32'(dut.state), 32'(IDLE));
    chk("flush_xn_hold", Xn, 32'h0);
    gap(8);
    chk("flush_idle", 32'(dut.state), 32'(IDLE));

    // Hold s_valid high: FIFO fills, nothing lost or duplicated.
    idx = 0;
    s_valid = 1'b1;
    s_data = 32'h4100_0000;
    for (int c = 0; c < 7; c++) begin
      acc = s_ready;
      tick;
      if (acc) idx++;
      s_data = 32'h4100_0000 + 32'(idx);
    end
    chk1("full_ready", s_ready, 1'b0);
    chk("accepts", 32'(idx), 32'd5);
    chk("full_xn0", Xn, 32'h4100_0000);
    s_valid = 1'b0;
    for (int i = 1; i < 5; i++) begin
      wait_stb(8);
      chk("full_seq", Xn, 32'h4100_0000 + 32'(i));
    end
    wait_stb(8);
    chk("full_tail_xn", Xn, 32'h0);
    chk1("full_tail_uf", underflow, 1'b1);

    // Shadow writes in IDLE, commit mid-COUNT.
    flush = 1'b1; tick; flush = 1'b0;
    coef_wr = 1'b1; coef_data = 32'h3E80_0000;
    for (int a = 0; a < 4; a++) begin
      coef_addr = 2'(a);
      tick;
    end
    coef_wr = 1'b0;
    chk("shadow_no_b0", b0, 32'h0);
    chk("shadow_no_b3", b3, 32'h0);
    s_valid = 1'b1; s_data = 32'h3F80_0000; tick;
    s_valid = 1'b0;
    coef_commit = 1'b1; tick;
    coef_commit = 1'b0;
    chk1("c2_pend", commit_pending, 1'b1);
    chk("c2_b0", b0, 32'h0);
    tick;
    chk1("c3_pend", commit_pending, 1'b1);
    chk1("c3_nostb", x_stb, 1'b0);
    tick;
    chk1("commit_stb", x_stb, 1'b1);
    chk("commit_b0", b0, 32'h3E80_0000);
    chk("commit_b1", b1, 32'h3E80_0000);
    chk("commit_b2", b2, 32'h3E80_0000);
    chk("commit_b3", b3, 32'h3E80_0000);
    chk1("commit_clear", commit_pending, 1'b0);
    chk("commit_xn", Xn, 32'h3F80_0000);

    // Coincident write and commit in IDLE.
    flush = 1'b1; tick; flush = 1'b0;
    coef_wr = 1'b1; coef_addr = 2'd2; coef_data = 32'h4120_0000;
    coef_commit = 1'b1; tick;
    coef_wr = 1'b0; coef_commit = 1'b0;
    chk("idle_b2", b2, 32'h4120_0000);
    chk("idle_b0", b0, 32'h3E80_0000);
    chk1("idle_pend", commit_pending, 1'b0);

    // Reset mid-COUNT discards the queue.
    s_valid = 1'b1; s_data = 32'h4080_0000; tick;
    s_data = 32'h4090_0000; tick;
    s_valid = 1'b0;
    Rst = 1'b0; tick;
    chk("mrst_xn", Xn, 32'h0);
    chk("mrst_b2", b2, 32'h0);
    chk("mrst_b0", b0, 32'h0);
    chk1("mrst_stb", x_stb, 1'b0);
    chk1("mrst_uf", underflow, 1'b0);
    chk1("mrst_pend", commit_pending, 1'b0);
    chk1("mrst_ready", s_ready, 1'b0);
    Rst = 1'b1; tick;
    chk1("mrst_ready_up", s_ready, 1'b1);
    gap(6);
    chk("mrst_idle", 32'(dut.state), 32'(IDLE));

`ifdef FP_FEEDER_NAN_SQUASH_EN
    s_valid = 1'b1; s_data = 32'h7FC0_0000; tick;
    s_valid = 1'b0;
    chk1("nan_pulse", nan_seen, 1'b1);
    tick;
    chk1("nan_pulse_end", nan_seen, 1'b0);
    wait_stb(8);
    chk("nan_xn", Xn, 32'h0);
    chk1("nan_no_uf", underflow, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
